// File: rtl/sd_cmd_framer.sv
// SD command framer: builds the 48-bit SPI-mode command frame with a bit-serial CRC7, hands it to the
// SPI master and scans the receive word for the R1 token. Optional watchdog: SD_CMD_TIMEOUT_EN.
module sd_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        spi_start_o,
  output logic [47:0] transmission_data_o,
  input  logic        spi_done_i,
  input  logic [79:0] received_data_i,
  output logic        resp_valid_o,
  output logic [7:0]  resp_r1_o,
  output logic [31:0] resp_tail_o,
  output logic        resp_timeout_o,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o
);

  // Command handshake: a command transfers on a rising edge where cmd_valid_i && cmd_ready_o.
  // Master handshake: spi_start_o is held until spi_done_i is seen low, then done rising ends the transfer.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRC    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_PARSE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [39:0] r_hdr;
  logic [39:0] r_sr;
  logic [6:0]  r_crc;
  logic [5:0]  r_bit_cnt;
  logic [47:0] r_tx;
  logic [79:0] r_scan;
  logic [6:0]  r_scan_cnt;
  logic [7:0]  r_r1;
  logic [31:0] r_tail;
  logic        r_timeout;

  logic        w_fb;
  logic [6:0]  w_crc_next;
  logic        w_crc_last;
  logic        w_token;
  logic        w_scan_exhausted;
  logic        w_tmo_hit;

  assign w_fb             = r_sr[39] ^ r_crc[6];
  assign w_crc_next       = {r_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
  assign w_crc_last       = (r_bit_cnt == 6'd39);
  assign w_token          = ~r_scan[79];
  assign w_scan_exhausted = (r_scan_cnt == 7'd72);

`ifdef SD_CMD_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] r_tmo_cnt;

  // Counts cycles spent in LAUNCH/WAIT; zeroed on the CRC->LAUNCH transition.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      r_tmo_cnt <= 24'd0;
    end else if (r_state == S_CRC && w_crc_last) begin
      r_tmo_cnt <= 24'd0;
    end else if (r_state == S_LAUNCH || r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
  end

  assign w_tmo_hit = (r_state == S_LAUNCH || r_state == S_WAIT) && (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo_hit = 1'b0;

  // Watchdog compiled out: TIMEOUT_CYCLES only gates this empty block.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready_o  = 1'b0;
    spi_start_o  = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) w_next = S_CRC;
      end
      S_CRC: begin
        if (w_crc_last) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        spi_start_o = 1'b1;
        if (w_tmo_hit) begin
          spi_start_o = 1'b0;
          w_next      = S_DONE;
        end else if (!spi_done_i) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tmo_hit)       w_next = S_DONE;
        else if (spi_done_i) w_next = S_PARSE;
      end
      S_PARSE: begin
        if (w_token || w_scan_exhausted) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      r_hdr      <= 40'd0;
      r_sr       <= 40'd0;
      r_crc      <= 7'd0;
      r_bit_cnt  <= 6'd0;
      r_tx       <= 48'hFFFF_FFFF_FFFF;
      r_scan     <= '1;
      r_scan_cnt <= 7'd0;
      r_r1       <= 8'hFF;
      r_tail     <= 32'hFFFF_FFFF;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_hdr     <= {2'b01, cmd_index_i, cmd_arg_i};
            r_sr      <= {2'b01, cmd_index_i, cmd_arg_i};
            r_crc     <= 7'd0;
            r_bit_cnt <= 6'd0;
            r_timeout <= 1'b0;
          end
        end
        S_CRC: begin
          r_sr      <= {r_sr[38:0], 1'b0};
          r_crc     <= w_crc_next;
          r_bit_cnt <= r_bit_cnt + 6'd1;
          if (w_crc_last) r_tx <= {r_hdr, w_crc_next, 1'b1};
        end
        S_LAUNCH, S_WAIT: begin
          if (w_tmo_hit) begin
            r_r1      <= 8'hFF;
            r_tail    <= 32'hFFFF_FFFF;
            r_timeout <= 1'b1;
          end else if (r_state == S_WAIT && spi_done_i) begin
            r_scan     <= received_data_i;
            r_scan_cnt <= 7'd0;
          end
        end
        S_PARSE: begin
          // A token still wins on the cycle the shift budget runs out.
          if (w_token) begin
            r_r1   <= r_scan[79:72];
            r_tail <= r_scan[71:40];
          end else if (w_scan_exhausted) begin
            r_r1      <= 8'hFF;
            r_tail    <= 32'hFFFF_FFFF;
            r_timeout <= 1'b1;
          end else begin
            r_scan     <= {r_scan[78:0], 1'b1};
            r_scan_cnt <= r_scan_cnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign transmission_data_o = r_tx;
  assign resp_r1_o           = r_r1;
  assign resp_tail_o         = r_tail;
  assign resp_timeout_o      = r_timeout;
  assign dbg_state_o         = r_state;

endmodule
